// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//
// Bus-master sequencer that drives the AHB UART peripheral over flat bus
// ports. After reset it writes the configuration register once. It then
// queues bytes from a streaming client in a small FIFO. For each queued byte it
// polls the UART status register until TX-ready is reported, and then writes
// the byte to the TX data register.
//
// Ports:
//   clk           system clock
//   nReset        asynchronous active-low reset
//   in_valid      client byte valid
//   in_data[7:0]  client byte
//   in_ready      FIFO can accept (push on in_valid && in_ready at posedge)
//   cfg_start     re-configuration request pulse, honoured only in IDLE
//   wen / ren     bus write / read request
//   addr[31:0]    bus offset address
//   wdata[31:0]   bus write data
//   strobe[3:0]   byte enables
//   rdata[31:0]   bus read data
//   request_stall peripheral wait state
//   error         peripheral error, sampled at completion
//   busy          not IDLE, or FIFO non-empty
//   err_sticky    set on any errored completion, cleared only by reset
//   fifo_count    current FIFO occupancy (0..DEPTH)

module uart_tx_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] CFG_ADDR     = 32'd24,
  parameter logic [31:0] CFG_VALUE    = 32'h0000_000F,
  parameter logic [31:0] TX_ADDR      = 32'd0,
  parameter logic [31:0] STATUS_ADDR  = 32'd4,
  parameter int unsigned TX_READY_BIT = 0
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     cfg_start,
  output logic                     wen,
  output logic                     ren,
  output logic [31:0]              addr,
  output logic [31:0]              wdata,
  output logic [3:0]               strobe,
  input  logic [31:0]              rdata,
  input  logic                     request_stall,
  input  logic                     error,
  output logic                     busy,
  output logic                     err_sticky,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // S_RETRY and S_ARM are the mandatory idle cycle after a status poll;
  // they differ only in where the sequencer goes next.
  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_POLL,
    S_RETRY,
    S_ARM,
    S_PUSH
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               started_q;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [7:0]         head_q;
  logic               err_q;

  logic               push;
  logic               pop;
  logic               bus_active;
  logic               done;
  logic               tx_ready;
  logic               fifo_empty;
  logic               unused_rdata;

  assign in_ready     = (count_q != FULL_COUNT);
  assign push         = in_valid && in_ready;
  assign fifo_empty   = (count_q == '0);
  assign tx_ready     = rdata[TX_READY_BIT];
  assign unused_rdata = ^rdata;

  // The state register sits in CFG during reset, but the first request is only
  // raised once started_q has seen a clock edge after release. This keeps every
  // bus output low while nReset is asserted.
  assign bus_active = started_q &&
                      ((state_q == S_CFG) || (state_q == S_POLL) || (state_q == S_PUSH));
  assign done       = bus_active && !request_stall;
  assign pop        = done && (state_q == S_PUSH);

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_CFG;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CFG: begin
        if (done) state_d = S_IDLE;
      end
      S_IDLE: begin
        // A push in this cycle already counts as work, which gives the
        // one-cycle push-to-read latency.
        if (cfg_start)                 state_d = S_CFG;
        else if (!fifo_empty || push)  state_d = S_POLL;
      end
      S_POLL: begin
        if (done) begin
          if (!error && tx_ready) state_d = S_ARM;
          else                    state_d = S_RETRY;
        end
      end
      S_RETRY: state_d = S_POLL;
      S_ARM:   state_d = S_PUSH;
      S_PUSH: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_CFG;
    endcase
  end

  // Output logic
  always_comb begin
    wen    = 1'b0;
    ren    = 1'b0;
    addr   = '0;
    wdata  = '0;
    strobe = '0;
    if (started_q) begin
      case (state_q)
        S_CFG: begin
          wen    = 1'b1;
          addr   = CFG_ADDR;
          wdata  = CFG_VALUE;
          strobe = 4'hF;
        end
        S_POLL: begin
          ren  = 1'b1;
          addr = STATUS_ADDR;
        end
        S_PUSH: begin
          wen    = 1'b1;
          addr   = TX_ADDR;
          wdata  = {24'b0, head_q};
          strobe = 4'h1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (started_q && (state_q != S_IDLE)) || !fifo_empty;
  assign err_sticky = err_q;
  assign fifo_count = count_q;

  // FIFO storage has no reset; the pointers being cleared is what empties it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The head byte is latched during S_ARM, so it is frozen for the whole
  // S_PUSH request. The FIFO is non-empty here, so a concurrent push can never
  // target the head slot.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      head_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_ARM) head_q <= mem[rd_ptr_q];
      if (done && error)    err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer
//
// Directed bench for uart_tx_sequencer. A small UART bus model answers
// requests on the falling edge. Stimulus pushes the expected bus writes and
// ready polls into a scoreboard queue, and the model pops and compares them as
// the DUT presents them.

module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        nReset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cfg_start;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        request_stall;
  logic        error;
  logic        busy;
  logic        err_sticky;
  logic [2:0]  fifo_count;

  uart_tx_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_start(cfg_start), .wen(wen), .ren(ren),
    .addr(addr), .wdata(wdata), .strobe(strobe), .rdata(rdata),
    .request_stall(request_stall), .error(error), .busy(busy),
    .err_sticky(err_sticky), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  txn_t sb[$];
  logic status_script[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic status_default = 1'b1;
  int   push_stall_cycles = 0;
  int   push_error_count  = 0;
  int   nr_polls = 0;
  int   last_push_len = 0;

  // Bus model state
  logic prev_req = 1'b0;
  logic last_done = 1'b0;
  logic req;
  logic st;
  int   stall_left = 0;
  int   req_cycles = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_cfg();
    sb.push_back('{w: 1'b1, a: 32'd24, d: 32'h0000_000F, s: 4'hF});
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sb.push_back('{w: 1'b0, a: 32'd4, d: 32'd0, s: 4'h0});
    sb.push_back('{w: 1'b1, a: 32'd0, d: {24'd0, b}, s: 4'h1});
  endtask

  task automatic compare_front(input string tag);
    txn_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_unexpected_req"}, 32'd1, 32'd0);
    end else begin
      e = sb[0];
      checkOutput({tag, "_kind_wen"}, {31'd0, wen}, {31'd0, e.w});
      checkOutput({tag, "_addr"}, addr, e.a);
      checkOutput({tag, "_strobe"}, {28'd0, strobe}, {28'd0, e.s});
      if (e.w) checkOutput({tag, "_wdata"}, wdata, e.d);
    end
  endtask

  // UART bus model: decides stall, rdata and error for each request cycle, and
  // checks the presented request against the scoreboard front.
  always @(negedge clk) begin
    req = wen || ren;
    rdata = '0;
    error = 1'b0;
    if (!nReset) begin
      prev_req = 1'b0;
      last_done = 1'b0;
      request_stall = 1'b0;
    end else begin
      if (req) begin
        checkOutput("idle_gap", {31'd0, last_done}, 32'd0);
        checkOutput("one_hot_wen_ren", {31'd0, wen && ren}, 32'd0);
        if (!prev_req) begin
          stall_left = (wen && addr == 32'd0) ? push_stall_cycles : 0;
          req_cycles = 0;
        end
        req_cycles++;
      end
      request_stall = req && (stall_left > 0);
      if (request_stall) stall_left--;
      if (req && ren && !request_stall) begin
        st = (status_script.size() > 0) ? status_script.pop_front() : status_default;
        rdata = {31'd0, st};
        if (!st) begin
          checkOutput("poll_addr", addr, 32'd4);
          checkOutput("poll_strobe", {28'd0, strobe}, 32'd0);
          nr_polls++;
        end else begin
          compare_front("ready_poll");
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end else if (req && wen) begin
        compare_front("write");
        if (!request_stall) begin
          if (addr == 32'd0 && push_error_count > 0) begin
            error = 1'b1;
            push_error_count--;
          end
          last_push_len = req_cycles;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
      last_done = req && !request_stall;
      prev_req = req;
    end
  end

  // Offers one byte and holds it until an edge with in_ready high accepts it.
  task automatic applyStimulus(input logic [7:0] b);
    logic took;
    int guard;
    guard = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    do begin
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 500);
    in_valid = 1'b0;
    if (!took) checkOutput("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(sb.size() == 0 && !busy && !wen && !ren) && guard < 500);
    checkOutput({name, "_drain_timeout"}, {31'd0, guard >= 500}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    nReset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_start = 1'b0;
    request_stall = 1'b0;
    rdata = '0;
    error = 1'b0;

    // Reset state and start-up configuration write
    repeat (3) @(negedge clk);
    checkOutput("rst_wen", {31'd0, wen}, 32'd0);
    checkOutput("rst_ren", {31'd0, ren}, 32'd0);
    checkOutput("rst_addr", addr, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err_sticky}, 32'd0);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    expect_cfg();
    @(posedge clk); #1 nReset = 1'b1;
    @(negedge clk);
    checkOutput("cfg_not_yet", {31'd0, wen}, 32'd0);
    @(negedge clk);
    checkOutput("cfg_wen_high", {31'd0, wen}, 32'd1);
    wait_idle("t1");
    checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("t1_idle_err", {31'd0, err_sticky}, 32'd0);
    checkOutput("t1_idle_wen", {31'd0, wen}, 32'd0);

    // Two bytes, ready status, no stall; checks push-to-read latency
    status_default = 1'b1;
    expect_byte(8'hA5);
    expect_byte(8'h3C);
    applyStimulus(8'hA5);
    @(negedge clk);
    checkOutput("latency_ren", {31'd0, ren}, 32'd1);
    applyStimulus(8'h3C);
    wait_idle("t2");
    checkOutput("t2_count", {29'd0, fifo_count}, 32'd0);

    // Three not-ready polls, then a push stalled for two cycles
    nr_polls = 0;
    status_script = '{1'b0, 1'b0, 1'b0};
    push_stall_cycles = 2;
    expect_byte(8'hB7);
    applyStimulus(8'hB7);
    wait_idle("t3");
    checkOutput("t3_notready_polls", nr_polls, 32'd3);
    checkOutput("t3_wen_cycles", last_push_len, 32'd3);
    push_stall_cycles = 0;

    // Fill the FIFO while the UART is never ready
    status_default = 1'b0;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    in_valid = 1'b1;
    in_data = 8'h05;
    repeat (3) @(negedge clk);
    checkOutput("t4_full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("t4_full_count", {29'd0, fifo_count}, 32'd4);
    expect_byte(8'h01);
    expect_byte(8'h02);
    expect_byte(8'h03);
    expect_byte(8'h04);
    expect_byte(8'h05);
    status_default = 1'b1;
    applyStimulus(8'h05);
    wait_idle("t4");
    checkOutput("t4_count", {29'd0, fifo_count}, 32'd0);

    // Errored push drops its byte; cfg_start preempts the next poll
    push_error_count = 1;
    expect_byte(8'h11);
    expect_byte(8'h22);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    wait_idle("t5");
    checkOutput("t5_err_sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("t5_count", {29'd0, fifo_count}, 32'd0);
    expect_cfg();
    expect_byte(8'h33);
    cfg_start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h33;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    in_valid = 1'b0;
    wait_idle("t5b");

    // Reset in the middle of a stalled push
    push_stall_cycles = 1000;
    expect_byte(8'h44);
    applyStimulus(8'h44);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(wen && addr == 32'd0) && guard < 100);
    repeat (2) @(negedge clk);
    checkOutput("t6_stalled_wen", {31'd0, wen}, 32'd1);
    nReset = 1'b0;
    #1;
    checkOutput("t6_rst_wen", {31'd0, wen}, 32'd0);
    checkOutput("t6_rst_ren", {31'd0, ren}, 32'd0);
    checkOutput("t6_rst_addr", addr, 32'd0);
    checkOutput("t6_rst_wdata", wdata, 32'd0);
    checkOutput("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("t6_rst_err", {31'd0, err_sticky}, 32'd0);
    sb.delete();
    push_stall_cycles = 0;
    expect_cfg();
    @(posedge clk); #1 nReset = 1'b1;
    wait_idle("t6");
    checkOutput("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
